// File: rtl/wishbone_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter granting whole cyc-bracketed bus cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin contests; default is fixed data-master priority.
module wishbone_bus_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // Instruction master
  input  logic [AW-1:0] iwb_addr_i,
  input  logic [DW-1:0] iwb_data_i,
  input  logic          iwb_we_i,
  input  logic [3:0]    iwb_sel_i,
  input  logic          iwb_stb_i,
  input  logic          iwb_cyc_i,
  output logic [DW-1:0] iwb_data_o,
  output logic          iwb_ack_o,
  // Data master
  input  logic [AW-1:0] dwb_addr_i,
  input  logic [DW-1:0] dwb_data_i,
  input  logic          dwb_we_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_cyc_i,
  output logic [DW-1:0] dwb_data_o,
  output logic          dwb_ack_o,
  // Slave
  output logic [AW-1:0] swb_addr_o,
  output logic [DW-1:0] swb_data_o,
  output logic          swb_we_o,
  output logic [3:0]    swb_sel_o,
  output logic          swb_stb_o,
  output logic          swb_cyc_o,
  input  logic [DW-1:0] swb_data_i,
  input  logic          swb_ack_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_i_q, last_i_d;
  state_e pick;

  // Arbitration on cyc only; a lone stb never requests.
  always_comb begin
    pick = StIdle;
    unique case ({dwb_cyc_i, iwb_cyc_i})
      2'b01:   pick = StGntI;
      2'b10:   pick = StGntD;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   pick = last_i_q ? StGntD : StGntI;
`else
      2'b11:   pick = StGntD;
`endif
      default: pick = StIdle;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    unique case (state_q)
      StGntI:  state_d = iwb_cyc_i ? StGntI : pick;
      StGntD:  state_d = dwb_cyc_i ? StGntD : pick;
      default: state_d = pick;
    endcase
    if (state_d == StGntI) begin
      last_i_d = 1'b1;
    end else if (state_d == StGntD) begin
      last_i_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      last_i_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_i_q <= last_i_d;
    end
  end

  always_comb begin
    swb_addr_o = '0;
    swb_data_o = '0;
    swb_we_o   = 1'b0;
    swb_sel_o  = 4'b0000;
    swb_stb_o  = 1'b0;
    swb_cyc_o  = 1'b0;
    iwb_data_o = '0;
    iwb_ack_o  = 1'b0;
    dwb_data_o = '0;
    dwb_ack_o  = 1'b0;
    unique case (state_q)
      StGntI: begin
        swb_addr_o = iwb_addr_i;
        swb_data_o = iwb_data_i;
        swb_we_o   = iwb_we_i;
        swb_sel_o  = iwb_sel_i;
        swb_stb_o  = iwb_stb_i;
        swb_cyc_o  = iwb_cyc_i;
        iwb_data_o = swb_data_i;
        iwb_ack_o  = swb_ack_i;
      end
      StGntD: begin
        swb_addr_o = dwb_addr_i;
        swb_data_o = dwb_data_i;
        swb_we_o   = dwb_we_i;
        swb_sel_o  = dwb_sel_i;
        swb_stb_o  = dwb_stb_i;
        swb_cyc_o  = dwb_cyc_i;
        dwb_data_o = swb_data_i;
        dwb_ack_o  = swb_ack_i;
      end
      default: ;
    endcase
  end

  assign gnt_o = {state_q == StGntD, state_q == StGntI};

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Directed self-checking bench for wishbone_bus_arbiter.
module tb_wishbone_bus_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] iwb_addr_i, dwb_addr_i, swb_addr_o;
  logic [DW-1:0] iwb_data_i, dwb_data_i, swb_data_o, swb_data_i;
  logic [DW-1:0] iwb_data_o, dwb_data_o;
  logic          iwb_we_i, iwb_stb_i, iwb_cyc_i, iwb_ack_o;
  logic          dwb_we_i, dwb_stb_i, dwb_cyc_i, dwb_ack_o;
  logic [3:0]    iwb_sel_i, dwb_sel_i, swb_sel_o;
  logic          swb_we_o, swb_stb_o, swb_cyc_o, swb_ack_i;
  logic [1:0]    gnt_o;

  int checks = 0;
  int errors = 0;

  wishbone_bus_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .iwb_addr_i (iwb_addr_i),
    .iwb_data_i (iwb_data_i),
    .iwb_we_i   (iwb_we_i),
    .iwb_sel_i  (iwb_sel_i),
    .iwb_stb_i  (iwb_stb_i),
    .iwb_cyc_i  (iwb_cyc_i),
    .iwb_data_o (iwb_data_o),
    .iwb_ack_o  (iwb_ack_o),
    .dwb_addr_i (dwb_addr_i),
    .dwb_data_i (dwb_data_i),
    .dwb_we_i   (dwb_we_i),
    .dwb_sel_i  (dwb_sel_i),
    .dwb_stb_i  (dwb_stb_i),
    .dwb_cyc_i  (dwb_cyc_i),
    .dwb_data_o (dwb_data_o),
    .dwb_ack_o  (dwb_ack_o),
    .swb_addr_o (swb_addr_o),
    .swb_data_o (swb_data_o),
    .swb_we_o   (swb_we_o),
    .swb_sel_o  (swb_sel_o),
    .swb_stb_o  (swb_stb_o),
    .swb_cyc_o  (swb_cyc_o),
    .swb_data_i (swb_data_i),
    .swb_ack_i  (swb_ack_i),
    .gnt_o      (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_all_zero(input string tag);
    check(tag, {swb_addr_o, swb_data_o}, 64'h0);
    check({tag, "_ctl"}, {57'h0, swb_we_o, swb_sel_o, swb_stb_o, swb_cyc_o}, 64'h0);
    check({tag, "_gnt"}, {62'h0, gnt_o}, 64'h0);
  endtask

  logic [1:0] rr_exp [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;
`else
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b10; rr_exp[2] = 2'b10; rr_exp[3] = 2'b10;
`endif
    rst = 1'b0;
    iwb_addr_i = '0; iwb_data_i = '0; iwb_we_i = 0; iwb_sel_i = '0; iwb_stb_i = 0; iwb_cyc_i = 0;
    dwb_addr_i = '0; dwb_data_i = '0; dwb_we_i = 0; dwb_sel_i = '0; dwb_stb_i = 0; dwb_cyc_i = 0;
    // Slave noise during reset must not leak to masters
    swb_data_i = 32'hDEAD_BEEF;
    swb_ack_i  = 1'b1;
    #3;
    slave_all_zero("reset");
    check("reset_acks", {62'h0, iwb_ack_o, dwb_ack_o}, 64'h0);
    check("reset_rdata", {iwb_data_o, dwb_data_o}, 64'h0);
    swb_data_i = '0;
    swb_ack_i  = 1'b0;
    #9 rst = 1'b1;
    tick();

    // Single instruction read
    iwb_cyc_i = 1; iwb_stb_i = 1; iwb_addr_i = 32'h0000_0010;
    #1;
    check("ird_latency_gnt", {62'h0, gnt_o}, 64'h0);
    check("ird_latency_cyc", {63'h0, swb_cyc_o}, 64'h0);
    tick();
    check("ird_gnt", {62'h0, gnt_o}, 64'h1);
    check("ird_addr", {32'h0, swb_addr_o}, 64'h10);
    check("ird_cycstb", {62'h0, swb_cyc_o, swb_stb_o}, 64'h3);
    tick();
    swb_ack_i = 1; swb_data_i = 32'h0000_0013;
    #1;
    check("ird_ack", {62'h0, iwb_ack_o, dwb_ack_o}, 64'h2);
    check("ird_rdata", {iwb_data_o, dwb_data_o}, 64'h0000_0013_0000_0000);
    tick();
    swb_ack_i = 0; swb_data_i = '0;
    iwb_cyc_i = 0; iwb_stb_i = 0;
    #1;
    check("ird_release_cyc", {63'h0, swb_cyc_o}, 64'h0);
    check("ird_release_gnt", {62'h0, gnt_o}, 64'h1);
    tick();
    check("ird_idle", {62'h0, gnt_o}, 64'h0);

    // Simultaneous requests: data master first, then instruction
    iwb_cyc_i = 1; iwb_stb_i = 1; iwb_addr_i = 32'h0000_0020; iwb_sel_i = 4'hF;
    dwb_cyc_i = 1; dwb_stb_i = 1; dwb_addr_i = 32'h0000_0100; dwb_we_i = 1;
    dwb_sel_i = 4'b0011; dwb_data_i = 32'hCAFE_F00D;
    tick();
    check("sim_gnt_d", {62'h0, gnt_o}, 64'h2);
    check("sim_addr", {32'h0, swb_addr_o}, 64'h100);
    check("sim_wdata", {32'h0, swb_data_o}, 64'hCAFE_F00D);
    check("sim_we_sel", {59'h0, swb_we_o, swb_sel_o}, 64'h13);
    swb_ack_i = 1;
    #1;
    check("sim_ack", {62'h0, iwb_ack_o, dwb_ack_o}, 64'h1);
    tick();
    swb_ack_i = 0;
    dwb_cyc_i = 0; dwb_stb_i = 0; dwb_we_i = 0;
    #1;
    check("sim_handover_m", {61'h0, swb_cyc_o, gnt_o}, 64'h2);
    tick();
    check("sim_gnt_i", {62'h0, gnt_o}, 64'h1);
    check("sim_i_addr_we", {31'h0, swb_we_o, swb_addr_o}, 64'h20);
    iwb_cyc_i = 0; iwb_stb_i = 0;
    tick();
    check("sim_idle", {62'h0, gnt_o}, 64'h0);

    // Contested grants from idle
    for (int r = 0; r < 4; r++) begin
      iwb_cyc_i = 1; iwb_stb_i = 1;
      dwb_cyc_i = 1; dwb_stb_i = 1;
      tick();
      check($sformatf("contest_%0d", r), {62'h0, gnt_o}, {62'h0, rr_exp[r]});
      iwb_cyc_i = 0; iwb_stb_i = 0;
      dwb_cyc_i = 0; dwb_stb_i = 0;
      tick();
      check($sformatf("contest_idle_%0d", r), {62'h0, gnt_o}, 64'h0);
    end

    // Block hold: data master keeps cyc across three beats
    iwb_cyc_i = 1; iwb_stb_i = 1;
    dwb_cyc_i = 1; dwb_stb_i = 1; dwb_we_i = 0;
    tick();
    for (int b = 0; b < 3; b++) begin
      dwb_stb_i = 1; swb_ack_i = 1;
      #1;
      check($sformatf("block_beat_%0d", b), {60'h0, gnt_o, iwb_ack_o, dwb_ack_o}, 64'h9);
      tick();
      swb_ack_i = 0; dwb_stb_i = 0;
      #1;
      check($sformatf("block_gap_%0d", b), {62'h0, gnt_o}, 64'h2);
      tick();
    end
    dwb_cyc_i = 0;
    tick();
    check("block_then_i", {62'h0, gnt_o}, 64'h1);
    iwb_cyc_i = 0; iwb_stb_i = 0;
    tick();

    // Asynchronous reset in the middle of a data transfer
    dwb_cyc_i = 1; dwb_stb_i = 1;
    tick();
    check("rst_pre_gnt", {62'h0, gnt_o}, 64'h2);
    #2 rst = 1'b0;
    #1;
    check("rst_async", {61'h0, swb_cyc_o, swb_stb_o, gnt_o[1]}, 64'h0);
    check("rst_async_gnt", {62'h0, gnt_o}, 64'h0);
    dwb_cyc_i = 0; dwb_stb_i = 0;
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_release_idle", {62'h0, gnt_o}, 64'h0);

    // Idle bus with stb/addr/data noise but no cyc
    for (int k = 0; k < 8; k++) begin
      iwb_stb_i = 1'($urandom); dwb_stb_i = 1'($urandom);
      iwb_addr_i = $urandom; dwb_addr_i = $urandom;
      iwb_data_i = $urandom; dwb_data_i = $urandom;
      iwb_we_i = 1'($urandom); dwb_we_i = 1'($urandom);
      iwb_sel_i = 4'($urandom); dwb_sel_i = 4'($urandom);
      tick();
      slave_all_zero($sformatf("idle_noise_%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/wishbone_bus_arbiter.md
# wishbone_bus_arbiter

Two-master, one-slave Wishbone arbiter. It lets the CPU's instruction-fetch bus interface and data-memory bus interface share a single unified memory or peripheral bus. The block sits between the two CPU-side Wishbone master ports and the single slave bus. It grants whole bus cycles, bracketed by `cyc`, to one master at a time and routes the slave's `ack` and read data back to the granted master only.

## Interface
- `DW`, 32: data width (matches `RegBus`).
- `AW`, 32: address width.
- One clock. Reset is asynchronous and active-low.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `iwb_addr_i` in AW: instruction master address.
- `iwb_data_i` in DW: instruction master write data.
- `iwb_we_i`, `iwb_stb_i`, `iwb_cyc_i` in 1 each: instruction master controls.
- `iwb_sel_i` in 4: instruction master byte selects.
- `iwb_data_o` out DW: read data to the instruction master.
- `iwb_ack_o` out 1: ack to the instruction master.
- `dwb_addr_i`, `dwb_data_i`, `dwb_we_i`, `dwb_sel_i`, `dwb_stb_i`, `dwb_cyc_i`, `dwb_data_o`, `dwb_ack_o`: same as the instruction set, for the data master.
- `swb_addr_o` out AW, `swb_data_o` out DW: slave address and write data.
- `swb_we_o`, `swb_stb_o`, `swb_cyc_o` out 1 each: slave controls.
- `swb_sel_o` out 4: slave byte selects.
- `swb_data_i` in DW, `swb_ack_i` in 1: slave read data and ack.
- `gnt_o` out 2: one-hot current grant. Bit 0 = instruction master, bit 1 = data master, 00 = idle.

## Operation
- State register values:
  - `IDLE`: no grant.
  - `GNT_I`: instruction master owns the bus.
  - `GNT_D`: data master owns the bus.
- A 1-bit `last_i` flag records whether the most recent grant went to the instruction master.
- Arbitration function `pick`, evaluated on the request vector `{dwb_cyc_i, iwb_cyc_i}`:
  - Only one master requesting: that master wins.
  - Both requesting: the data master wins by default. See Configuration for the round-robin alternative.
  - Neither requesting: `IDLE`.
- Transitions:
  - `IDLE` → `pick` on every clock edge.
  - `GNT_x` → stays in `GNT_x` while the granted master's `cyc_i` = 1.
  - `GNT_x` → `pick` on the first edge where the granted master's `cyc_i` = 0. This can go directly to the other master's grant state with no idle cycle.
  - `last_i` updates on every entry to a `GNT` state.
- Slave outputs:
  - In a `GNT` state, all six `swb_*_o` signals are a combinational mux of the granted master's inputs.
  - In `IDLE`, all slave outputs are 0.
- Master return path:
  - `xwb_ack_o` = `swb_ack_i` AND (state == `GNT_x`).
  - `xwb_data_o` = `swb_data_i` when granted, otherwise 0.
  - A non-granted master never sees an ack. It waits with `cyc`/`stb` held, as the Wishbone rules require.
- The arbiter never preempts a cycle. A block transfer (`cyc` held across several `stb`/`ack` pairs) completes atomically.
- `gnt_o` is decoded directly from the state register.

## Timing
- Reset state while `rst` = 0, applied immediately (asynchronous):
  - State = `IDLE`, `last_i` = 1.
  - All `swb_*_o` = 0, both `ack_o` = 0, both `data_o` = 0, `gnt_o` = 00.
- Arbitration latency from an idle bus: a request whose `cyc` rises in cycle N drives `swb_cyc_o`/`swb_stb_o` from cycle N+1.
- The slave's `ack` reaches the granted master combinationally, in the same cycle.
- Handover: the owner drops `cyc` in cycle M → the new owner's signals appear on the slave bus in cycle M+1. In cycle M, `swb_cyc_o` already reads 0 because it follows the owner.
- A request that arrives in the same cycle the owner releases is treated as simultaneous with any other pending request.
- Reset asserted mid-transfer: `swb_cyc_o`/`swb_stb_o` drop asynchronously and the transfer is abandoned. On release, arbitration restarts from `IDLE`.
- A `stb` without `cyc` from either master is ignored; it neither requests nor holds a grant.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, the master not named by `last_i` wins.
  - The first contested grant after reset goes to the data master, because `last_i` = 1.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the data master always wins a contest.
  - `last_i` is still maintained, so the reset behaviour is the same.

## Test plan
- Single instruction read: `iwb_cyc_i`/`stb_i` = 1 at addr 0x0000_0010, slave acks with 0x0000_0013 one cycle after `swb_stb_o` → `gnt_o` = 01 one cycle after the request, `iwb_data_o` = 0x13 with `iwb_ack_o` = 1 in the ack cycle, `dwb_ack_o` stays 0.
- Simultaneous requests, fixed priority: both `cyc` rise together → `gnt_o` = 10 first. The data master's store to 0x100 (`we` = 1, `sel` = 4'b0011) appears on the slave bus. The instruction grant follows the cycle after `dwb_cyc_i` falls.
- Round-robin (`ARB_ROUND_ROBIN_EN`): both masters request continuously for 4 single-beat cycles → grant sequence is D, I, D, I.
- Block hold: the data master keeps `cyc` = 1 across 3 acked beats while the instruction master requests → `gnt_o` stays 10 for all 3 beats with no instruction ack.
- Reset mid-transfer: drive `rst` = 0 while in `GNT_D` with `stb` high → `swb_cyc_o`/`swb_stb_o` = 0 and `gnt_o` = 00 without waiting for a clock edge. After release with no requests, the arbiter stays in `IDLE`.
- Idle bus: no `cyc` asserted, random `stb`, addr and data toggling → all `swb_*_o` remain 0 and `gnt_o` = 00.
